// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin arbiter that shares one external combinational adder between
//   NREQ requesters. Each cycle at most one valid request is granted, its
//   operands are steered onto the adder, and the resulting sum is captured
//   together with the winner's index in a single-entry response slot that
//   honours consumer backpressure.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, combinational)
//   req_a      packed operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand b, same packing
//   add_a      operand a to the shared adder
//   add_b      operand b to the shared adder
//   add_sum    sum returned by the shared adder
//   rsp_valid  response slot full
//   rsp_ready  consumer accepts the response
//   rsp_id     index of the requester that produced rsp_sum
//   rsp_sum    registered sum
//   busy_cnt   saturating count of accepted requests
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic [15:0]           busy_cnt
);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   next_ptr;
    logic             slot_free;
    logic             grant_valid;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    // Unpack the flat operand buses into per-requester arrays.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_a[i] = req_a[i*WIDTH +: WIDTH];
            op_b[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // The slot can take a new result if it is empty or being drained now.
    assign slot_free = !rsp_valid || rsp_ready;

    // Round-robin search starting at ptr. Gating with reset_n keeps the
    // arbiter quiet (no accept, zero adder operands) while reset is held.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (reset_n && slot_free) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = IDW'((32'(ptr) + k) % 32'(NREQ));
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (grant_valid) begin
            add_a = op_a[grant_idx];
            add_b = op_b[grant_idx];
        end
    end

    // Explicit wrap so non-power-of-two NREQ also returns to zero.
    assign next_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            busy_cnt  <= '0;
        end else begin
            if (grant_valid) begin
                rsp_valid <= 1'b1;
                rsp_id    <= grant_idx;
                rsp_sum   <= add_sum;
                ptr       <= next_ptr;
                if (busy_cnt != '1) begin
                    busy_cnt <= busy_cnt + 16'd1;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_sum;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic [15:0]           busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // expected responses: {id, sum}
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    // The shared adder lives outside the arbiter.
    assign add_sum = add_a + add_b;

    adder_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .busy_cnt (busy_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after posedge, check the combinational
    // grant on the negedge, record the expected response if it fires.
    task automatic step(input logic [3:0] v, input logic rr, input logic rst,
                        input logic [3:0] exp_ready, input logic [1:0] exp_id,
                        input logic [7:0] exp_sum);
        reset_n   = rst;
        req_valid = v;
        rsp_ready = rr;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (exp_ready != 4'b0000) begin
            exp_q.push_back({6'b0, exp_id, exp_sum});
        end else begin
            chk("adder_idle", 32'({add_a, add_b}), 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is consumed whenever valid and ready coincide.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
                    chk("rsp_sum", 32'(rsp_sum), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // operands: sums 11, 22, 33, 44 for requesters 0..3
        req_a     = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b     = {8'h04, 8'h03, 8'h02, 8'h01};
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
        chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_add_ab", 32'({add_a, add_b}), 32'h0);
        @(posedge clk);
        #1;

        // single request on requester 2
        req_a[23:16] = 8'h12;
        req_b[23:16] = 8'h34;
        step(4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h46);
        chk("busy_after_first", 32'(busy_cnt), 32'd1);
        req_a[23:16] = 8'h30;
        req_b[23:16] = 8'h03;

        // overflow on requester 3 (ptr is 3)
        req_a[31:24] = 8'hFF;
        req_b[31:24] = 8'h02;
        step(4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h01);
        req_a[31:24] = 8'h40;
        req_b[31:24] = 8'h04;

        // all valid: 0,1,2,3,0 back to back
        step(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h11);
        step(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h22);
        step(4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h33);
        step(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h44);
        step(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h11);

        // backpressure: slot holds {0, 11} for three cycles
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 8'h00);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_id", 32'(rsp_id), 32'h0);
            chk("bp_rsp_sum", 32'(rsp_sum), 32'h11);
        end
        // release: grant fires in the same cycle (ptr is 1)
        step(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h22);

        // wrap and skip
        step(4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h44);
        step(4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h22);
        // ptr must now be 2: of {1,3} the search from 2 picks 3
        step(4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h44);

        // requester 2 drops valid while the slot is stalled
        step(4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0, 8'h00);
        step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 8'h00);
        step(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h11);
        step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 8'h00);
        step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 8'h00);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("busy_count", 32'(busy_cnt), 32'd12);

        // reset mid-operation with a pending response
        step(4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h33);
        chk("pending_before_rst", 32'(rsp_valid), 32'h1);
        step(4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
        exp_q.delete();
        reset_n = 1'b1;
        #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_busy", 32'(busy_cnt), 32'h0);
        // ptr restarted at 0: lowest valid index (1) wins over 3
        step(4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h22);
        step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 8'h00);
        chk("busy_after_rst", 32'(busy_cnt), 32'd1);
        step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 8'h00);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
